// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction-fetch
// requester (IF) and the load/store requester (D). One transaction outstanding at a
// time. D has priority, bounded by a starvation counter that hands IF the port once
// D has been granted STARVE_MAX times in a row while IF was waiting.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [AW-1:0]     if_req_addr,
  output logic              if_rsp_valid,
  output logic [DW-1:0]     if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [AW-1:0]     d_req_addr,
  input  logic [DW-1:0]     d_req_wdata,
  input  logic [DW/8-1:0]   d_req_be,
  output logic              d_rsp_valid,
  output logic [DW-1:0]     d_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [AW-1:0]     mem_req_addr,
  output logic [DW-1:0]     mem_req_wdata,
  output logic [DW/8-1:0]   mem_req_be,
  input  logic              mem_rsp_valid,
  input  logic [DW-1:0]     mem_rsp_data,
  output logic              err_spurious
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       owner_d;    // 1 = outstanding transaction belongs to D
  logic       grant_if;
  logic       grant_d;
  logic       starved;

  assign starved = (starve_cnt == 4'(STARVE_MAX));

  // Combinational grant in IDLE; readies are forced low while reset is asserted.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE && rst) begin
      if (d_req_valid && !(if_req_valid && starved)) begin
        grant_d = 1'b1;
      end else if (if_req_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  // Transaction FSM: capture the winner, hold the memory request, route the response.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      starve_cnt    <= 4'd0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_be    <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      d_rsp_valid   <= 1'b0;
      d_rsp_data    <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless re-armed below.
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state         <= ISSUE;
            owner_d       <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_we    <= d_req_we;
            mem_req_addr  <= d_req_addr;
            mem_req_wdata <= d_req_wdata;
            mem_req_be    <= d_req_be;
            // Count D wins only while IF is actually waiting.
            if (if_req_valid) begin
              if (!starved) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
            end
          end else if (grant_if) begin
            state         <= ISSUE;
            owner_d       <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= if_req_addr;
            mem_req_wdata <= '0;
            mem_req_be    <= '1;
            starve_cnt    <= 4'd0;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (owner_d) begin
              d_rsp_valid <= 1'b1;
              // A store completes with an ack carrying zero data.
              d_rsp_data  <= mem_req_we ? '0 : mem_rsp_data;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag for a memory response arriving when nothing is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_spurious <= 1'b0;
    end else if (mem_rsp_valid && state != WAIT) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_valid;
  logic            if_req_ready;
  logic [AW-1:0]   if_req_addr;
  logic            if_rsp_valid;
  logic [DW-1:0]   if_rsp_data;
  logic            d_req_valid;
  logic            d_req_ready;
  logic            d_req_we;
  logic [AW-1:0]   d_req_addr;
  logic [DW-1:0]   d_req_wdata;
  logic [DW/8-1:0] d_req_be;
  logic            d_rsp_valid;
  logic [DW-1:0]   d_rsp_data;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_be;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            err_spurious;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_be      (d_req_be),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_be    (mem_req_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_req_we"},    mem_req_we,    0);
    check({tag, "_mem_req_addr"},  mem_req_addr,  0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_mem_req_be"},    mem_req_be,    0);
    check({tag, "_if_req_ready"},  if_req_ready,  0);
    check({tag, "_d_req_ready"},   d_req_ready,   0);
    check({tag, "_if_rsp_valid"},  if_rsp_valid,  0);
    check({tag, "_d_rsp_valid"},   d_rsp_valid,   0);
    check({tag, "_if_rsp_data"},   if_rsp_data,   0);
    check({tag, "_d_rsp_data"},    d_rsp_data,    0);
    check({tag, "_err_spurious"},  err_spurious,  0);
  endtask

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst           = 1'b1;
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h0;
    d_req_valid   = 1'b1;
    d_req_we      = 1'b0;
    d_req_addr    = 32'h0;
    d_req_wdata   = 32'h0;
    d_req_be      = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;

    // Power-on reset with both requesters valid: readies must stay gated.
    #2 rst = 1'b0;
    #1;
    check_all_zero("por");
    step();
    check_all_zero("por_held");

    // IF alone, address 0x100.
    rst           = 1'b1;
    d_req_valid   = 1'b0;
    if_req_addr   = 32'h100;
    mem_req_ready = 1'b1;
    #1;
    check("if_alone_if_ready", if_req_ready, 1);
    check("if_alone_d_ready",  d_req_ready,  0);
    step();
    if_req_valid = 1'b0;
    #1;
    check("if_alone_mem_valid", mem_req_valid, 1);
    check("if_alone_mem_addr",  mem_req_addr,  32'h100);
    check("if_alone_mem_be",    mem_req_be,    4'hF);
    check("if_alone_mem_we",    mem_req_we,    0);
    check("if_alone_mem_wdata", mem_req_wdata, 0);
    step();
    check("if_alone_wait_valid", mem_req_valid, 0);
    step();
    check("if_alone_no_early_rsp", if_rsp_valid, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("if_alone_rsp_valid", if_rsp_valid, 1);
    check("if_alone_rsp_data",  if_rsp_data,  32'hDEADBEEF);
    check("if_alone_d_rsp",     d_rsp_valid,  0);
    step();
    check("if_alone_pulse_end", if_rsp_valid, 0);
    check("if_alone_data_hold", if_rsp_data,  32'hDEADBEEF);

    // Simultaneous IF (0x300) and D store 0x55AA to 0x200, be=3: D first.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h300;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    d_req_addr   = 32'h200;
    d_req_wdata  = 32'h55AA;
    d_req_be     = 4'h3;
    #1;
    check("sim_d_ready",  d_req_ready,  1);
    check("sim_if_ready", if_req_ready, 0);
    step();
    d_req_valid = 1'b0;
    #1;
    check("sim_store_we",    mem_req_we,    1);
    check("sim_store_addr",  mem_req_addr,  32'h200);
    check("sim_store_wdata", mem_req_wdata, 32'h55AA);
    check("sim_store_be",    mem_req_be,    4'h3);
    check("sim_issue_if_ready", if_req_ready, 0);
    step();
    check("sim_wait_if_ready", if_req_ready, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h12345678;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("sim_d_rsp_valid",  d_rsp_valid,  1);
    check("sim_d_rsp_zero",   d_rsp_data,   0);
    check("sim_if_rsp_quiet", if_rsp_valid, 0);
    check("sim_if_granted",   if_req_ready, 1);
    step();
    if_req_valid = 1'b0;
    #1;
    check("sim_if_addr",  mem_req_addr,  32'h300);
    check("sim_if_we",    mem_req_we,    0);
    check("sim_if_be",    mem_req_be,    4'hF);
    check("sim_if_wdata", mem_req_wdata, 0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEF00D;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("sim_if_rsp_valid", if_rsp_valid, 1);
    check("sim_if_rsp_data",  if_rsp_data,  32'hCAFEF00D);
    check("sim_d_rsp_quiet",  d_rsp_valid,  0);

    // Starvation: both valid continuously, expected grants D,D,D,D,IF,D.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h700;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 32'h600;
    d_req_be     = 4'hF;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_d_ready_%0d", i),  d_req_ready,  exp_d[i]);
      check($sformatf("starve_if_ready_%0d", i), if_req_ready, !exp_d[i]);
      step();
      check($sformatf("starve_addr_%0d", i), mem_req_addr, exp_d[i] ? 32'h600 : 32'h700);
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'(i);
      step();
      mem_rsp_valid = 1'b0;
      #1;
      check($sformatf("starve_d_rsp_%0d", i),  d_rsp_valid,  exp_d[i]);
      check($sformatf("starve_if_rsp_%0d", i), if_rsp_valid, !exp_d[i]);
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;

    // Backpressure: D load 0x400 with memory not ready for 5 cycles.
    step();
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h400;
    mem_req_ready = 1'b0;
    #1;
    check("bp_d_ready", d_req_ready, 1);
    step();
    d_req_valid  = 1'b0;
    if_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k),    mem_req_valid, 1);
      check($sformatf("bp_addr_%0d", k),     mem_req_addr,  32'h400);
      check($sformatf("bp_we_%0d", k),       mem_req_we,    0);
      check($sformatf("bp_if_ready_%0d", k), if_req_ready,  0);
      check($sformatf("bp_d_ready_%0d", k),  d_req_ready,   0);
      check($sformatf("bp_d_rsp_%0d", k),    d_rsp_valid,   0);
      step();
    end
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("bp_still_valid", mem_req_valid, 1);
    step();
    check("bp_accepted", mem_req_valid, 0);

    // Back-to-back: new D request present in the response cycle.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hA5A5A5A5;
    d_req_valid   = 1'b1;
    d_req_addr    = 32'h500;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("b2b_rsp_valid", d_rsp_valid, 1);
    check("b2b_rsp_data",  d_rsp_data,  32'hA5A5A5A5);
    check("b2b_d_ready",   d_req_ready, 1);
    step();
    d_req_valid = 1'b0;
    #1;
    check("b2b_mem_valid",  mem_req_valid, 1);
    check("b2b_mem_addr",   mem_req_addr,  32'h500);
    check("b2b_pulse_end",  d_rsp_valid,   0);
    check("b2b_data_hold",  d_rsp_data,    32'hA5A5A5A5);
    step();
    check("b2b_in_wait",    mem_req_valid, 0);
    check("no_spurious_yet", err_spurious, 0);

    // Reset while the D load is outstanding, then a late memory response.
    rst          = 1'b0;
    d_req_valid  = 1'b1;
    if_req_valid = 1'b1;
    #1;
    check_all_zero("midwait_rst");
    step();
    check_all_zero("midwait_rst_held");
    d_req_valid  = 1'b0;
    if_req_valid = 1'b0;
    rst          = 1'b1;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h77;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("late_rsp_err",      err_spurious,  1);
    check("late_rsp_d_quiet",  d_rsp_valid,   0);
    check("late_rsp_if_quiet", if_rsp_valid,  0);
    check("late_rsp_d_data",   d_rsp_data,    0);
    check("late_rsp_mem_idle", mem_req_valid, 0);
    step();
    check("late_rsp_err_sticky", err_spurious, 1);
    check("late_rsp_d_still",    d_rsp_valid,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
